// File: rtl/rv64_pkg.sv
// Shared definitions for the rv64IM pipeline: data width, load/store
// funct3 encodings and the memory-stage state type.
package rv64_pkg;

    localparam int unsigned XLEN = 64;

    // Load funct3 encodings. Stores reuse the low two bits as access size.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper for the memory stage: alignment check, store lane
// replication and byte mask, and load extract with sign/zero extension.
module mem_align
    import rv64_pkg::*;
(
    input  logic [2:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [7:0]      wmask_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted;

    // Access must be naturally aligned to its size (funct3[1:0]).
    always_comb begin
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'd0:    misalign_o = 1'b0;
            2'd1:    misalign_o = addr_lo_i[0];
            2'd2:    misalign_o = |addr_lo_i[1:0];
            default: misalign_o = |addr_lo_i;
        endcase
    end

    // Replicate store data into every lane of its size and place the byte mask.
    always_comb begin
        wdata_o   = store_data_i;
        base_mask = 8'hFF;
        case (funct3_i[1:0])
            2'd0: begin
                wdata_o   = {8{store_data_i[7:0]}};
                base_mask = 8'h01;
            end
            2'd1: begin
                wdata_o   = {4{store_data_i[15:0]}};
                base_mask = 8'h03;
            end
            2'd2: begin
                wdata_o   = {2{store_data_i[31:0]}};
                base_mask = 8'h0F;
            end
            default: begin
                wdata_o   = store_data_i;
                base_mask = 8'hFF;
            end
        endcase
        wmask_o = base_mask << addr_lo_i;
    end

    // Move the addressed bytes down to bit 0 and extend per funct3.
    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        load_data_o = shifted;
        case (funct3_i)
            F3_LB:   load_data_o = {{56{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   load_data_o = shifted;
            F3_LBU:  load_data_o = {56'd0, shifted[7:0]};
            F3_LHU:  load_data_o = {48'd0, shifted[15:0]};
            F3_LWU:  load_data_o = {32'd0, shifted[31:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through one register, issues
// loads/stores over a request/grant + response handshake and stalls
// execute while an access is outstanding.
module mem_stage
    import rv64_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            wen_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic            exit_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] a0_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wmask_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            valid_o,
    output logic            wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            exit_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] a0_o,
    output logic            misalign_o
);

    mem_state_e state_q, state_d;

    // Captured memory instruction
    logic [XLEN-1:0] addr_q, sdata_q, pc_q, a0_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            wen_q, store_q, exit_q;

    // Output bundle
    logic            ovalid_q, ovalid_d;
    logic            owen_q, owen_d;
    logic [4:0]      ord_q, ord_d;
    logic [XLEN-1:0] odata_q, odata_d;
    logic            oexit_q, oexit_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [XLEN-1:0] oa0_q, oa0_d;
    logic            omis_q, omis_d;

    logic            mem_op, idle, capture;
    logic [2:0]      al_addr, al_f3;
    logic            al_misalign;
    logic [XLEN-1:0] al_wdata, al_load;
    logic [7:0]      al_wmask;

    assign mem_op = mem_read_i | mem_write_i;
    assign idle   = (state_q == MEM_IDLE);

    // One aligner is shared: in IDLE it checks the incoming address, otherwise
    // it works on the captured access. dmem outputs are gated outside REQ.
    assign al_addr = idle ? alu_result_i[2:0] : addr_q[2:0];
    assign al_f3   = idle ? funct3_i : f3_q;

    mem_align u_align (
        .addr_lo_i    (al_addr),
        .funct3_i     (al_f3),
        .store_data_i (sdata_q),
        .rdata_i      (dmem_rdata_i),
        .misalign_o   (al_misalign),
        .wdata_o      (al_wdata),
        .wmask_o      (al_wmask),
        .load_data_o  (al_load)
    );

    assign capture = idle && valid_i && mem_op && !al_misalign;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= MEM_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (capture) state_d = MEM_REQ;
            MEM_REQ:  if (dmem_gnt_i) state_d = store_q ? MEM_IDLE : MEM_RESP;
            MEM_RESP: if (dmem_rvalid_i) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // FSM outputs: handshake to execute and the memory request
    always_comb begin
        ready_o      = idle;
        dmem_req_o   = (state_q == MEM_REQ);
        dmem_we_o    = dmem_req_o && store_q;
        dmem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
        dmem_wdata_o = dmem_req_o ? al_wdata : '0;
        dmem_wmask_o = dmem_req_o ? al_wmask : '0;
    end

    // Capture the memory instruction when it is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            sdata_q <= '0;
            pc_q    <= '0;
            a0_q    <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            store_q <= 1'b0;
            exit_q  <= 1'b0;
        end else if (capture) begin
            addr_q  <= alu_result_i;
            sdata_q <= store_data_i;
            pc_q    <= pc_i;
            a0_q    <= a0_i;
            f3_q    <= funct3_i;
            rd_q    <= rd_i;
            wen_q   <= wen_i;
            store_q <= mem_write_i;
            exit_q  <= exit_i;
        end
    end

    // Next output bundle; edges that load nothing leave a bubble
    always_comb begin
        ovalid_d = 1'b0;
        owen_d   = 1'b0;
        oexit_d  = 1'b0;
        omis_d   = 1'b0;
        ord_d    = ord_q;
        odata_d  = odata_q;
        opc_d    = opc_q;
        oa0_d    = oa0_q;
        case (state_q)
            MEM_IDLE: begin
                if (valid_i && (!mem_op || al_misalign)) begin
                    ovalid_d = 1'b1;
                    owen_d   = mem_op ? 1'b0 : wen_i;
                    omis_d   = mem_op;
                    ord_d    = rd_i;
                    odata_d  = alu_result_i;
                    oexit_d  = exit_i;
                    opc_d    = pc_i;
                    oa0_d    = a0_i;
                end
            end
            MEM_REQ: begin
                if (dmem_gnt_i && store_q) begin
                    ovalid_d = 1'b1;
                    ord_d    = rd_q;
                    odata_d  = addr_q;
                    oexit_d  = exit_q;
                    opc_d    = pc_q;
                    oa0_d    = a0_q;
                end
            end
            MEM_RESP: begin
                if (dmem_rvalid_i) begin
                    ovalid_d = 1'b1;
                    owen_d   = wen_q;
                    ord_d    = rd_q;
                    odata_d  = al_load;
                    oexit_d  = exit_q;
                    opc_d    = pc_q;
                    oa0_d    = a0_q;
                end
            end
            default: ;
        endcase
    end

    // Output bundle register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid_q <= 1'b0;
            owen_q   <= 1'b0;
            ord_q    <= '0;
            odata_q  <= '0;
            oexit_q  <= 1'b0;
            opc_q    <= '0;
            oa0_q    <= '0;
            omis_q   <= 1'b0;
        end else begin
            ovalid_q <= ovalid_d;
            owen_q   <= owen_d;
            ord_q    <= ord_d;
            odata_q  <= odata_d;
            oexit_q  <= oexit_d;
            opc_q    <= opc_d;
            oa0_q    <= oa0_d;
            omis_q   <= omis_d;
        end
    end

    assign valid_o    = ovalid_q;
    assign wen_o      = owen_q;
    assign rd_o       = ord_q;
    assign rf_wdata_o = odata_q;
    assign exit_o     = oexit_q;
    assign pc_o       = opc_q;
    assign a0_o       = oa0_q;
    assign misalign_o = omis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected writeback bundles.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, wen_i;
    logic [4:0]  rd_i;
    logic [63:0] alu_result_i, store_data_i;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic        exit_i;
    logic [63:0] pc_i, a0_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wmask_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        valid_o, wen_o;
    logic [4:0]  rd_o;
    logic [63:0] rf_wdata_o;
    logic        exit_o;
    logic [63:0] pc_o, a0_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .wen_i(wen_i), .rd_i(rd_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .funct3_i(funct3_i), .exit_i(exit_i),
        .pc_i(pc_i), .a0_i(a0_i), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .wen_o(wen_o),
        .rd_o(rd_o), .rf_wdata_o(rf_wdata_o), .exit_o(exit_o),
        .pc_o(pc_o), .a0_o(a0_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        chk_data;
        logic        exitv;
        logic        mis;
        logic [63:0] pc;
        logic [63:0] a0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one cycle, sample after the edge, retire any produced bundle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {63'd0, valid_o}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_wen", {63'd0, wen_o}, {63'd0, e.wen});
                chk("sb_rd", {59'd0, rd_o}, {59'd0, e.rd});
                if (e.chk_data) chk("sb_wdata", rf_wdata_o, e.data);
                chk("sb_exit", {63'd0, exit_o}, {63'd0, e.exitv});
                chk("sb_misalign", {63'd0, misalign_o}, {63'd0, e.mis});
                chk("sb_pc", pc_o, e.pc);
                chk("sb_a0", a0_o, e.a0);
            end
        end
    endtask

    task automatic idle_in();
        valid_i = 1'b0; wen_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        exit_i = 1'b0; funct3_i = 3'd0;
    endtask

    task automatic push(input logic w, input logic [4:0] r, input logic [63:0] d,
                        input logic cd, input logic ex, input logic m,
                        input logic [63:0] p, input logic [63:0] a);
        exp_t e;
        e.wen = w; e.rd = r; e.data = d; e.chk_data = cd; e.exitv = ex;
        e.mis = m; e.pc = p; e.a0 = a;
        sb.push_back(e);
    endtask

    task automatic drive_alu(input logic [4:0] r, input logic [63:0] res,
                             input logic ex, input logic [63:0] p, input logic [63:0] a);
        idle_in();
        valid_i = 1'b1; wen_i = 1'b1; rd_i = r; alu_result_i = res;
        exit_i = ex; pc_i = p; a0_i = a;
        push(1'b1, r, res, 1'b1, ex, 1'b0, p, a);
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] rdata, input logic [63:0] exp, input string tag);
        logic [63:0] aligned;
        aligned = addr & ~64'h7;
        idle_in();
        valid_i = 1'b1; mem_read_i = 1'b1; wen_i = 1'b1; rd_i = 5'd10;
        funct3_i = f3; alu_result_i = addr; pc_i = addr + 64'h100; a0_i = 64'h5A;
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        push(1'b1, 5'd10, exp, 1'b1, 1'b0, 1'b0, addr + 64'h100, 64'h5A);
        tick();
        idle_in();
        chk({tag, "_req"}, {63'd0, dmem_req_o}, 64'd1);
        chk({tag, "_we"}, {63'd0, dmem_we_o}, 64'd0);
        chk({tag, "_addr"}, dmem_addr_o, aligned);
        chk({tag, "_stall"}, {63'd0, ready_o}, 64'd0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk({tag, "_no_early_valid"}, {63'd0, valid_o}, 64'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        tick();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk({tag, "_latency3"}, {63'd0, valid_o}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        rd_i = '0; alu_result_i = '0; store_data_i = '0; pc_i = '0; a0_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_wdata", rf_wdata_o, 64'd0);
        chk("rst_req", {63'd0, dmem_req_o}, 64'd0);
        chk("rst_wmask", {56'd0, dmem_wmask_o}, 64'd0);

        // Back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'(5 + i), 64'h11 * (i + 1), 1'b0, 64'h100 + 64'(4 * i), 64'(i + 1));
            chk("burst_ready", {63'd0, ready_o}, 64'd1);
            tick();
            chk("burst_valid", {63'd0, valid_o}, 64'd1);
        end
        idle_in();
        tick();
        chk("burst_bubble", {63'd0, valid_o}, 64'd0);

        // Loads
        do_load(64'h1003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        do_load(64'h1003, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, "lbu");
        do_load(64'h1004, 3'b010, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, "lw");
        do_load(64'h1002, 3'b101, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D, "lhu");
        do_load(64'h1008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "ld");

        // SH with grant held off three cycles
        idle_in();
        valid_i = 1'b1; mem_write_i = 1'b1; wen_i = 1'b1; rd_i = 5'd3;
        funct3_i = 3'b001; alu_result_i = 64'h2006; store_data_i = 64'hBEEF;
        pc_i = 64'h400; a0_i = 64'h7;
        push(1'b0, 5'd3, 64'd0, 1'b0, 1'b0, 1'b0, 64'h400, 64'h7);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            dmem_gnt_i = (i == 3);
            chk("sh_req", {63'd0, dmem_req_o}, 64'd1);
            chk("sh_we", {63'd0, dmem_we_o}, 64'd1);
            chk("sh_wmask", {56'd0, dmem_wmask_o}, 64'hC0);
            chk("sh_addr", dmem_addr_o, 64'h2000);
            chk("sh_wdata_hi", {48'd0, dmem_wdata_o[63:48]}, 64'hBEEF);
            chk("sh_stall", {63'd0, ready_o}, 64'd0);
            tick();
        end
        dmem_gnt_i = 1'b0;
        chk("sh_done_valid", {63'd0, valid_o}, 64'd1);
        chk("sh_done_ready", {63'd0, ready_o}, 64'd1);

        // Misaligned LW
        idle_in();
        valid_i = 1'b1; mem_read_i = 1'b1; wen_i = 1'b1; rd_i = 5'd9;
        funct3_i = 3'b010; alu_result_i = 64'h3002; pc_i = 64'h500; a0_i = 64'h8;
        push(1'b0, 5'd9, 64'd0, 1'b0, 1'b0, 1'b1, 64'h500, 64'h8);
        chk("mis_no_req", {63'd0, dmem_req_o}, 64'd0);
        tick();
        idle_in();
        chk("mis_valid", {63'd0, valid_o}, 64'd1);
        chk("mis_flag", {63'd0, misalign_o}, 64'd1);
        chk("mis_no_req_after", {63'd0, dmem_req_o}, 64'd0);
        chk("mis_ready", {63'd0, ready_o}, 64'd1);

        // Exit passthrough then bubble
        drive_alu(5'd10, 64'h0, 1'b1, 64'h600, 64'h0);
        tick();
        chk("exit_high", {63'd0, exit_o}, 64'd1);
        idle_in();
        tick();
        chk("exit_cleared", {63'd0, exit_o}, 64'd0);
        chk("exit_bubble_valid", {63'd0, valid_o}, 64'd0);

        // Reset while waiting for a load response
        idle_in();
        valid_i = 1'b1; mem_read_i = 1'b1; wen_i = 1'b1; rd_i = 5'd12;
        funct3_i = 3'b011; alu_result_i = 64'h4000; pc_i = 64'h700; a0_i = 64'h9;
        tick();
        idle_in();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("rstm_in_resp", {63'd0, ready_o}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("rstm_ready", {63'd0, ready_o}, 64'd1);
        chk("rstm_valid", {63'd0, valid_o}, 64'd0);
        chk("rstm_rd", {59'd0, rd_o}, 64'd0);
        chk("rstm_wdata", rf_wdata_o, 64'd0);
        chk("rstm_pc", pc_o, 64'd0);
        chk("rstm_a0", a0_o, 64'd0);
        chk("rstm_req", {63'd0, dmem_req_o}, 64'd0);
        tick();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk("rstm_stray_rvalid", {63'd0, valid_o}, 64'd0);
        tick();
        chk("rstm_idle_valid", {63'd0, valid_o}, 64'd0);
        chk("rstm_idle_ready", {63'd0, ready_o}, 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the rv64IM pipeline, between execute and writeback. Non-memory instructions pass through one register level. Loads and stores are issued to the data memory over a request/grant plus response handshake. Load data is byte-lane extracted and sign/zero extended before reaching the writeback port (`wen_o`, `rd_o`, `rf_wdata_o`, `exit_o`, `pc_o`, `a0_o`). The stage stalls execute via `ready_o` while a memory access is outstanding.

## Interface
- No parameters; XLEN fixed at 64.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: execute presents an instruction.
- `ready_o` out 1: stage accepts an instruction this cycle; high only in IDLE.
- `wen_i`, `rd_i[4:0]` in: register-file write enable and destination.
- `alu_result_i` in 64: result for non-memory ops, byte address for memory ops.
- `store_data_i` in 64: rs2 value for stores.
- `mem_read_i`, `mem_write_i` in 1: load or store. Both high is illegal and is treated as a store.
- `funct3_i` in 3: access size and signedness.
- `exit_i`, `pc_i[63:0]`, `a0_i[63:0]` in: debug sideband, carried with the instruction.
- `dmem_req_o` out 1, `dmem_we_o` out 1, `dmem_addr_o` out 64 (bits [2:0]=0), `dmem_wdata_o` out 64, `dmem_wmask_o` out 8: memory request.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1, `dmem_rdata_i` in 64: load response, a full aligned doubleword.
- `valid_o`, `wen_o`, `rd_o[4:0]`, `rf_wdata_o[63:0]`, `exit_o`, `pc_o[63:0]`, `a0_o[63:0]` out: registered writeback bundle.
- `misalign_o` out 1: registered, qualifies `valid_o`; the completing access was misaligned.

## Operation
- States: IDLE, REQ, RESP.
- IDLE, `valid_i`, no memory op: the output bundle loads from the inputs at this edge (`rf_wdata_o = alu_result_i`). State stays IDLE.
- IDLE, `valid_i`, memory op, aligned access: capture address, data, funct3, rd, wen and sideband. Go to REQ.
- Aligned means: byte always; half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
- Misaligned memory op: no memory access. The output bundle loads with `wen_o=0` and `misalign_o=1`. State stays IDLE.
- REQ: `dmem_req_o=1`, driven from the captured registers. Requests are held stable until grant.
  - Store: wdata is store data replicated into every lane of its size; wmask is 0x01/0x03/0x0F/0xFF shifted left by addr[2:0].
  - On `dmem_gnt_i`, store: load the output bundle with `wen_o=0`; go to IDLE.
  - On `dmem_gnt_i`, load: go to RESP.
- RESP: on `dmem_rvalid_i`, shift rdata right by 8·addr[2:0] and extend per funct3:
  - LB=000, LH=001, LW=010 sign-extend.
  - LD=011 takes the full doubleword.
  - LBU=100, LHU=101, LWU=110 zero-extend.
  - The result loads into `rf_wdata_o` with the captured `wen`/`rd`. Go to IDLE.
- Bubble: any edge that does not load the bundle clears `valid_o`, `wen_o`, `exit_o` and `misalign_o`. `rd_o`, `rf_wdata_o`, `pc_o` and `a0_o` hold their values. A stale exit therefore never reaches writeback twice.
- Memory contract: `dmem_rvalid_i` arrives at least one cycle after grant. `dmem_rvalid_i` outside RESP is ignored. `dmem_gnt_i` outside REQ is ignored.
- Reset, including mid-access: state goes to IDLE. All outputs go to 0, and `ready_o` goes to 1 after the edge. A grant or response pending at reset is dropped.

## Timing
- Non-memory op: output visible the cycle after acceptance (latency 1). Back-to-back throughput is 1 per cycle.
- Store with immediate grant: latency 2.
- Load with immediate grant and response one cycle later: latency 3.
- `ready_o` is combinational from state only. It never depends on `valid_i` or on memory inputs.
- `dmem_*` outputs are combinational from state and the captured registers; there is no path from `valid_i` to `dmem_req_o`.

## Structure
- Shared package `rv64_pkg`:
  - funct3 load/store constants (`F3_LB` … `F3_LWU`).
  - State enum (`MEM_IDLE`, `MEM_REQ`, `MEM_RESP`).
  - XLEN = 64.
- Sub-module `mem_align`, purely combinational:
  - misalignment check;
  - store lane replication and mask generation;
  - load extract and extend.
- `mem_stage` holds the FSM, the capture registers and the output register.

## Test plan
- Non-memory burst:
  - Stimulus: three back-to-back ALU ops (rd=5/6/7, results 0x11/0x22/0x33).
  - Required: `ready_o` constant 1; outputs appear on consecutive cycles with latency 1.
- LB sign extension:
  - Stimulus: addr 0x1003, rdata 0x0000_0000_8000_0000, grant and response immediate.
  - Required: `rf_wdata_o`=0xFFFF_FFFF_FFFF_FF80 three cycles after acceptance.
  - Same stimulus with LBU: required 0x80.
- SH with delayed grant:
  - Stimulus: addr 0x2006, data 0xBEEF, grant held off 3 cycles.
  - Required: wmask=0xC0 and addr=0x2000 held stable, wdata[63:48]=0xBEEF, `ready_o`=0 throughout; then `valid_o`=1 with `wen_o`=0.
- Misaligned LW:
  - Stimulus: LW at addr 0x3002.
  - Required: no `dmem_req_o`; next cycle `valid_o`=1, `misalign_o`=1, `wen_o`=0.
- Exit passthrough:
  - Stimulus: `exit_i`=1 with a0=0, followed by a bubble.
  - Required: `exit_o` high exactly one cycle.
- Reset mid-load:
  - Stimulus: assert `rst` in RESP, then a stray `dmem_rvalid_i`.
  - Required: outputs 0 and `ready_o`=1 after reset; no `valid_o` is produced.
